// File: rtl/franken_io_pkg.sv
// franken_io_pkg: register map, status bit indices and
// UART state type shared across the franken IO page.
package franken_io_pkg;

    localparam int IO_LEDS_BIT      = 0;
    localparam int IO_UART_DAT_BIT  = 1;
    localparam int IO_UART_CNTL_BIT = 2;

    localparam int ST_RX_VALID = 8;
    localparam int ST_TX_BUSY  = 9;
    localparam int ST_TX_FULL  = 10;
    localparam int ST_RX_OVR   = 11;
    localparam int ST_RX_FERR  = 12;
    localparam int ST_TX_OVF   = 13;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/franken_io_if.sv
// franken_io_if: Mem-stage bus between the core and
// the IO page (one-hot word select, strobes, read data).
interface franken_io_if;

    logic [2:0]  io_wordaddr;
    logic [31:0] io_wdata;
    logic        io_wstrb;
    logic        io_rstrb;
    logic [31:0] io_rdata;

    modport master (
        output io_wordaddr,
        output io_wdata,
        output io_wstrb,
        output io_rstrb,
        input  io_rdata
    );

    modport slave (
        input  io_wordaddr,
        input  io_wdata,
        input  io_wstrb,
        input  io_rstrb,
        output io_rdata
    );

endinterface

// File: rtl/franken_uart_rx.sv
// franken_uart_rx: 8N1 receiver with 2-flop synchroniser,
// holding register and sticky overrun/framing flags.
module franken_uart_rx
    import franken_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_byte,
    input  logic       clr_err,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ovr,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // sync[1] is the synchronised line, sync[2] its previous value
    logic [2:0]    sync;
    logic          rx_s;
    logic          rx_fall;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    nbit;
    logic [7:0]    shift;
    logic          tick;
    logic          half;
    logic          stop_ok;
    logic          stop_bad;

    assign rx_s     = sync[1];
    assign rx_fall  = sync[2] & ~sync[1];
    assign tick     = cnt == BIT_END;
    assign half     = cnt == HALF_END;
    assign stop_ok  = state == UART_STOP && tick && rx_s;
    assign stop_bad = state == UART_STOP && tick && !rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '1;
            state <= UART_IDLE;
            cnt   <= '0;
            nbit  <= '0;
            shift <= '0;
        end else begin
            sync <= {sync[1:0], rxd};
            cnt  <= cnt + 1'b1;
            unique case (state)
                UART_IDLE: begin
                    cnt <= '0;
                    if (rx_fall) state <= UART_START;
                end
                UART_START: if (half) begin
                    cnt   <= '0;
                    nbit  <= '0;
                    state <= rx_s ? UART_IDLE : UART_DATA;
                end
                UART_DATA: if (tick) begin
                    cnt   <= '0;
                    shift <= {rx_s, shift[7:1]};
                    nbit  <= nbit + 1'b1;
                    if (nbit == 3'd7) state <= UART_STOP;
                end
                UART_STOP: if (tick) begin
                    cnt   <= '0;
                    state <= UART_IDLE;
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

    // a byte load beats a concurrent read of the holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            if (clr_err) begin
                rx_ovr  <= 1'b0;
                rx_ferr <= 1'b0;
            end
            if (rd_byte) rx_valid <= 1'b0;
            if (stop_ok) begin
                rx_byte  <= shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_byte) rx_ovr <= 1'b1;
            end
            if (stop_bad) rx_ferr <= 1'b1;
        end
    end

endmodule

// File: rtl/franken_io.sv
// franken_io: memory-mapped IO page with LED register,
// FIFO-buffered UART transmitter and UART receiver.
module franken_io
    import franken_io_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int NUM_LEDS    = 5,
    parameter int TX_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    franken_io_if.slave         bus,
    output logic [NUM_LEDS-1:0] LEDS,
    output logic                TXD,
    input  logic                RXD
);

    localparam int CPB = CLK_FREQ_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int PW  = $clog2(TX_DEPTH);
    localparam int QW  = PW + 1;
    localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
    localparam logic [QW-1:0] DEPTH   = QW'(TX_DEPTH);

    if (CPB < 4) begin : g_cpb_chk
        $error("franken_io: CLKS_PER_BIT must be >= 4");
    end
    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("franken_io: TX_DEPTH must be a power of two >= 2");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_leds_chk
        $error("franken_io: NUM_LEDS must be 1..32");
    end

    logic [2:0]  sel;
    logic        one_hot;
    logic        multi;
    logic        wr_leds;
    logic        wr_dat;
    logic        rd_dat;
    logic        rd_cntl;
    logic [31:0] status;
    logic        unused_wdata;

    assign sel     = bus.io_wordaddr;
    assign one_hot = sel != 3'b0 && (sel & (sel - 3'd1)) == 3'b0;
    assign multi   = sel != 3'b0 && !one_hot;
    assign wr_leds = bus.io_wstrb && one_hot && sel[IO_LEDS_BIT];
    assign wr_dat  = bus.io_wstrb && one_hot && sel[IO_UART_DAT_BIT];
    assign rd_dat  = bus.io_rstrb && one_hot && sel[IO_UART_DAT_BIT];
    assign rd_cntl = bus.io_rstrb && one_hot && sel[IO_UART_CNTL_BIT];
    assign unused_wdata = ^bus.io_wdata;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ovr;
    logic       rx_ferr;

    franken_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rxd     (RXD),
        .rd_byte (rd_dat),
        .clr_err (rd_cntl),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ovr  (rx_ovr),
        .rx_ferr (rx_ferr)
    );

    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [QW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          tx_ovf;
    uart_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_nbit;
    logic [7:0]    tx_shift;
    logic          tx_tick;

    assign empty   = count == '0;
    assign full    = count == DEPTH;
    assign tx_tick = tx_cnt == BIT_END;
    // popping at the end of STOP chains frames with no idle bit
    assign pop  = !empty && (tx_state == UART_IDLE ||
                  (tx_state == UART_STOP && tx_tick));
    assign push = wr_dat && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.io_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + QW'(push) - QW'(pop);
            if (rd_cntl) tx_ovf <= 1'b0;
            if (wr_dat && !push) tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= UART_IDLE;
            tx_cnt   <= '0;
            tx_nbit  <= '0;
            tx_shift <= '0;
            TXD      <= 1'b1;
        end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            unique case (tx_state)
                UART_IDLE: begin
                    tx_cnt <= '0;
                    if (pop) begin
                        tx_state <= UART_START;
                        tx_shift <= fifo[rd_ptr];
                        TXD      <= 1'b0;
                    end
                end
                UART_START: if (tx_tick) begin
                    tx_state <= UART_DATA;
                    tx_nbit  <= '0;
                    TXD      <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                end
                UART_DATA: if (tx_tick) begin
                    if (tx_nbit == 3'd7) begin
                        tx_state <= UART_STOP;
                        TXD      <= 1'b1;
                    end else begin
                        tx_nbit  <= tx_nbit + 1'b1;
                        TXD      <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                UART_STOP: if (tx_tick) begin
                    if (pop) begin
                        tx_state <= UART_START;
                        tx_shift <= fifo[rd_ptr];
                        TXD      <= 1'b0;
                    end else begin
                        tx_state <= UART_IDLE;
                    end
                end
                default: tx_state <= UART_IDLE;
            endcase
        end
    end

    always_comb begin
        status              = '0;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TX_BUSY]  = !empty || tx_state != UART_IDLE;
        status[ST_TX_FULL]  = full;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_RX_FERR]  = rx_ferr;
        status[ST_TX_OVF]   = tx_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            LEDS         <= '0;
            bus.io_rdata <= '0;
        end else begin
            if (wr_leds) LEDS <= bus.io_wdata[NUM_LEDS-1:0];
            if (bus.io_rstrb && sel != 3'b0) begin
                if (multi) begin
                    bus.io_rdata <= '0;
                end else begin
                    unique case (1'b1)
                        sel[IO_LEDS_BIT]:      bus.io_rdata <= 32'(LEDS);
                        sel[IO_UART_DAT_BIT]:  bus.io_rdata <= {24'b0, rx_byte};
                        sel[IO_UART_CNTL_BIT]: bus.io_rdata <= status;
                        default:               bus.io_rdata <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_franken_io.sv
// tb_franken_io: directed + randomized checks of the franken
// IO page against a register-level reference model.
module tb_franken_io;

    localparam int CPB  = 10;
    localparam int LOGN = 8192;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic [4:0] leds;
    logic       txd;

    franken_io_if bus ();

    franken_io #(
        .CLK_FREQ_HZ(10_000_000),
        .BAUD       (1_000_000),
        .NUM_LEDS   (5),
        .TX_DEPTH   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .LEDS (leds),
        .TXD  (txd),
        .RXD  (rxd)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic txd_log [LOGN];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < LOGN) txd_log[cyc] <= txd;

    int vec  = 0;
    int errs = 0;

    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_txovf = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    logic [4:0] m_leds  = 5'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                             output int c);
        @(negedge clk);
        bus.io_wordaddr = a;
        bus.io_wdata    = d;
        bus.io_wstrb    = 1'b1;
        c               = cyc;
        @(negedge clk);
        bus.io_wstrb    = 1'b0;
        bus.io_wordaddr = 3'b000;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.io_wordaddr = a;
        bus.io_rstrb    = 1'b1;
        @(negedge clk);
        bus.io_rstrb    = 1'b0;
        bus.io_wordaddr = 3'b000;
        d               = bus.io_rdata;
    endtask

    function automatic logic [31:0] exp_cntl(input logic busy,
                                             input logic full);
        return {18'b0, m_txovf, m_ferr, m_ovr, full, busy, m_valid, 8'h00};
    endfunction

    task automatic read_cntl(input string tag, input logic busy,
                             input logic full);
        logic [31:0] d;
        bus_read(3'b100, d);
        chk(tag, d, exp_cntl(busy, full));
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_txovf = 1'b0;
    endtask

    task automatic read_dat(input string tag);
        logic [31:0] d;
        bus_read(3'b010, d);
        chk(tag, d, {24'b0, m_byte});
        m_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd = fr[k];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_byte  = b;
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic check_frame(input string tag, input int start,
                               input logic [7:0] b);
        int   diffs;
        int   k;
        logic e;
        diffs = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            k = i / CPB;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            if (txd_log[start + i] !== e) diffs++;
        end
        chk(tag, 32'(diffs), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] v;
        logic [7:0]  b;
        logic [7:0]  x;
        int          c;
        int          c0;

        bus.io_wordaddr = 3'b000;
        bus.io_wdata    = '0;
        bus.io_wstrb    = 1'b0;
        bus.io_rstrb    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rdata", bus.io_rdata, 32'd0);
        reset = 1'b0;

        bus_write(3'b001, 32'h0000_0015, c);
        m_leds = 5'h15;
        chk("leds_wr", 32'(leds), 32'(m_leds));
        bus_read(3'b001, d);
        chk("leds_rd", d, 32'h15);

        for (int i = 0; i < 4; i++) begin
            v = $urandom | 32'h1;
            bus_write(3'b001, v, c);
            m_leds = v[4:0];
            chk("leds_rand", 32'(leds), 32'(m_leds));
            bus_read(3'b001, d);
            chk("leds_rand_rd", d, 32'(m_leds));
        end

        repeat (4) @(negedge clk);
        chk("rdata_hold", bus.io_rdata, 32'(m_leds));
        bus_read(3'b101, d);
        chk("multi_rd", d, 32'd0);
        bus_write(3'b011, ~32'(m_leds), c);
        chk("multi_wr_leds", 32'(leds), 32'(m_leds));
        bus_write(3'b000, ~32'(m_leds), c);
        chk("zero_wr_leds", 32'(leds), 32'(m_leds));
        bus_write(3'b100, 32'hFFFF_FFFF, c);
        read_cntl("cntl_wr_ignored", 1'b0, 1'b0);

        bus_write(3'b010, 32'h0000_00A5, c);
        read_cntl("a5_busy", 1'b1, 1'b0);
        repeat (110) @(negedge clk);
        chk("a5_latency", 32'(txd_log[c + 1]), 32'd1);
        check_frame("a5_frame", c + 2, 8'hA5);
        chk("a5_after", 32'(txd_log[c + 102]), 32'd1);
        read_cntl("a5_idle", 1'b0, 1'b0);

        b = 8'($urandom);
        bus_write(3'b010, 32'(b), c);
        repeat (110) @(negedge clk);
        check_frame("rand_frame", c + 2, b);

        bus_write(3'b010, 32'h01, c0);
        for (int i = 2; i <= 5; i++) bus_write(3'b010, 32'(i), c);
        bus_write(3'b010, 32'h66, c);
        m_txovf = 1'b1;
        read_cntl("fifo_full_ovf", 1'b1, 1'b1);
        read_cntl("ovf_cleared", 1'b1, 1'b1);
        repeat (500) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_frame("burst_frame", c0 + 2 + 100 * i, 8'(i + 1));
        end
        chk("burst_end", 32'(txd_log[c0 + 502]), 32'd1);
        chk("burst_drop", 32'(txd_log[c0 + 510]), 32'd1);
        read_cntl("burst_idle", 1'b0, 1'b0);

        send_rx(8'h3C, 1'b1);
        read_cntl("rx_valid", 1'b0, 1'b0);
        read_dat("rx_3c");
        read_cntl("rx_cleared", 1'b0, 1'b0);

        b = 8'($urandom);
        send_rx(b, 1'b1);
        read_dat("rx_rand");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        read_cntl("rx_ovr", 1'b0, 1'b0);
        read_dat("rx_ovr_byte");
        read_cntl("rx_ovr_clr", 1'b0, 1'b0);

        x = 8'($urandom);
        send_rx(x, 1'b1);
        b = 8'($urandom);
        send_rx(b, 1'b0);
        read_cntl("rx_ferr", 1'b0, 1'b0);
        read_dat("rx_ferr_keep");
        read_cntl("rx_ferr_clr", 1'b0, 1'b0);

        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        read_cntl("rx_glitch", 1'b0, 1'b0);

        bus_write(3'b010, 32'h00, c);
        bus_write(3'b010, 32'h00, c0);
        repeat (37) @(negedge clk);
        chk("pre_rst_txd", 32'(txd), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", 32'(txd), 32'd1);
        reset  = 1'b0;
        m_leds = 5'h00;
        chk("mid_rst_leds", 32'(leds), 32'(m_leds));
        read_cntl("mid_rst_fifo", 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("post_rst_txd", 32'(txd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
